// File: rtl/fetch_pc_steer.sv
// fetch_pc_steer: owns the IF program counter, carries predictions through IF/ID and
// resolves branches in ID. Define BPU_STATS_EN to build the saturating branch statistics.
module fetch_pc_steer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        predict,
  input  logic [31:0] predictedPC,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic        valid_ID,
  output logic        pred_taken_ID,
  output logic [31:0] pred_target_ID,
  input  logic        B_valid,
  input  logic        Branch_ID,
  input  logic [31:0] jump_PC_ID,
  output logic        flush,
  output logic [31:0] redirect_PC,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        resolve;
  logic        dir_miss;
  logic        tgt_miss;
  logic        mispredict;
  logic [31:0] pc_id_plus4;
  logic [31:0] pc_next;

  // Only a real, non-held ID branch in steady state can be judged against its prediction.
  assign resolve     = valid_ID & B_valid & ~stall & (state_q == RUN);
  assign dir_miss    = Branch_ID != pred_taken_ID;
  assign tgt_miss    = Branch_ID & (jump_PC_ID != pred_target_ID);
  assign mispredict  = resolve & (dir_miss | tgt_miss);
  assign pc_id_plus4 = PC_ID + 32'd4;

  assign flush       = mispredict;
  assign redirect_PC = Branch_ID ? jump_PC_ID : pc_id_plus4;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    pc_next = PC_IF + 32'd4;
    state_d = state_q;

    if (stall) begin
      pc_next = PC_IF;
    end else if (mispredict) begin
      pc_next = redirect_PC;
    end else if (predict) begin
      pc_next = predictedPC;
    end

    if (!stall) begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (mispredict) state_d = RECOVER;
        RECOVER: state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q        <= BOOT;
      PC_IF          <= RESET_PC;
      PC_ID          <= '0;
      valid_ID       <= 1'b0;
      pred_taken_ID  <= 1'b0;
      pred_target_ID <= '0;
    end else if (!stall) begin
      state_q        <= state_d;
      PC_IF          <= pc_next;
      PC_ID          <= PC_IF;
      pred_taken_ID  <= predict;
      pred_target_ID <= predictedPC;
      // The boot fetch and the flushed fetch both enter ID as bubbles.
      valid_ID       <= ~mispredict & (state_q != BOOT);
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] n_branches_q;
  logic [31:0] n_mispredicts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_branches_q    <= '0;
      n_mispredicts_q <= '0;
    end else begin
      if (resolve && (n_branches_q != 32'hFFFF_FFFF)) begin
        n_branches_q <= n_branches_q + 32'd1;
      end
      if (mispredict && (n_mispredicts_q != 32'hFFFF_FFFF)) begin
        n_mispredicts_q <= n_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = n_branches_q;
  assign stat_mispredicts = n_mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_steer.sv
// Self-checking bench for fetch_pc_steer: directed vector table, hand sequences for
// stats/reset-in-recovery, and randomized traffic against a behavioural model.
module tb_fetch_pc_steer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        predict = 1'b0;
  logic [31:0] predictedPC = '0;
  logic [31:0] PC_IF;
  logic [31:0] PC_ID;
  logic        valid_ID;
  logic        pred_taken_ID;
  logic [31:0] pred_target_ID;
  logic        B_valid = 1'b0;
  logic        Branch_ID = 1'b0;
  logic [31:0] jump_PC_ID = '0;
  logic        flush;
  logic [31:0] redirect_PC;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  fetch_pc_steer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .predict(predict), .predictedPC(predictedPC),
    .PC_IF(PC_IF), .PC_ID(PC_ID), .valid_ID(valid_ID), .pred_taken_ID(pred_taken_ID),
    .pred_target_ID(pred_target_ID), .B_valid(B_valid), .Branch_ID(Branch_ID),
    .jump_PC_ID(jump_PC_ID), .flush(flush), .redirect_PC(redirect_PC),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } id_rec_t;

  logic [31:0] m_pc;
  id_rec_t     m_id;
  bit          m_booted;
  logic [31:0] m_nbr;
  logic [31:0] m_nmis;

  task automatic model_reset();
    m_pc     = RST_PC;
    m_id     = '0;
    m_booted = 1'b0;
    m_nbr    = '0;
    m_nmis   = '0;
  endtask

  // A prediction is right when both say not-taken, or both say taken to the same place.
  function automatic logic m_judged(input logic st, input logic bv);
    return m_id.valid && bv && !st;
  endfunction

  function automatic logic m_wrong(input logic st, input logic bv, input logic br,
                                   input logic [31:0] jpc);
    logic right;
    right = br ? (m_id.taken && (m_id.target == jpc)) : !m_id.taken;
    return m_judged(st, bv) && !right;
  endfunction

  function automatic logic [31:0] m_fix(input logic br, input logic [31:0] jpc);
    return br ? jpc : m_id.pc + 32'd4;
  endfunction

  task automatic model_edge(input logic st, input logic pr, input logic [31:0] pp,
                            input logic bv, input logic br, input logic [31:0] jpc);
    logic        wrong;
    logic [31:0] fix;
    if (!st) begin
      wrong = m_wrong(st, bv, br, jpc);
      fix   = m_fix(br, jpc);
      if (m_judged(st, bv) && m_nbr != 32'hFFFF_FFFF) m_nbr = m_nbr + 1;
      if (wrong && m_nmis != 32'hFFFF_FFFF) m_nmis = m_nmis + 1;
      m_id.valid  = !wrong && m_booted;
      m_id.pc     = m_pc;
      m_id.taken  = pr;
      m_id.target = pp;
      m_pc        = wrong ? fix : (pr ? pp : m_pc + 32'd4);
      m_booted    = 1'b1;
    end
  endtask

  task automatic compare_all(input logic st, input logic bv, input logic br,
                             input logic [31:0] jpc);
    logic wrong;
    wrong = m_wrong(st, bv, br, jpc);
    check("flush", {31'd0, flush}, {31'd0, wrong});
    if (wrong) check("redirect_PC", redirect_PC, m_fix(br, jpc));
    check("PC_IF", PC_IF, m_pc);
    check("PC_ID", PC_ID, m_id.pc);
    check("valid_ID", {31'd0, valid_ID}, {31'd0, m_id.valid});
    check("pred_taken_ID", {31'd0, pred_taken_ID}, {31'd0, m_id.taken});
    check("pred_target_ID", pred_target_ID, m_id.target);
`ifdef BPU_STATS_EN
    check("stat_branches", stat_branches, m_nbr);
    check("stat_mispredicts", stat_mispredicts, m_nmis);
`else
    check("stat_branches", stat_branches, 32'd0);
    check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
  endtask

  // Called at posedge+1: drive, check mid-cycle, clock, advance model.
  task automatic cyc(input logic st, input logic pr, input logic [31:0] pp,
                     input logic bv, input logic br, input logic [31:0] jpc);
    stall = st; predict = pr; predictedPC = pp;
    B_valid = bv; Branch_ID = br; jump_PC_ID = jpc;
    #4;
    compare_all(st, bv, br, jpc);
    @(posedge clk);
    model_edge(st, pr, pp, bv, br, jpc);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; predict = 0; predictedPC = '0; B_valid = 0; Branch_ID = 0; jump_PC_ID = '0;
  endtask

  // Holds reset across an edge and releases it at posedge+1, ahead of the BOOT edge.
  task automatic release_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        st;
    logic        pr;
    logic [31:0] pp;
    logic        bv;
    logic        br;
    logic [31:0] jpc;
    logic        e_flush;
    logic [31:0] e_redir;
    logic [31:0] e_pc_if;
    logic [31:0] e_pc_id;
    logic        e_valid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic pr, input logic [31:0] pp,
                              input logic bv, input logic br, input logic [31:0] jpc,
                              input logic ef, input logic [31:0] er, input logic [31:0] epc,
                              input logic [31:0] eid, input logic ev);
    vec_t v;
    v.st = st; v.pr = pr; v.pp = pp; v.bv = bv; v.br = br; v.jpc = jpc;
    v.e_flush = ef; v.e_redir = er; v.e_pc_if = epc; v.e_pc_id = eid; v.e_valid = ev;
    return v;
  endfunction

  vec_t vecs [22];

  initial begin
    logic        r_st, r_pr, r_bv, r_br;
    logic [31:0] r_pp, r_jpc;

    //            st pr pp             bv br jpc        fl redir         pc_if          pc_id          v
    vecs[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,        32'h104,       32'h100,       0);
    vecs[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,        32'h108,       32'h104,       1);
    vecs[2]  = mk(0, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,        32'h10C,       32'h108,       1);
    vecs[3]  = mk(0, 1, 32'h200,       0, 0, 32'h0,     0, 32'h0,        32'h200,       32'h10C,       1);
    vecs[4]  = mk(0, 1, 32'h240,       0, 0, 32'h0,     0, 32'h0,        32'h240,       32'h200,       1);
    vecs[5]  = mk(0, 0, 32'h0,         1, 1, 32'h240,   0, 32'h0,        32'h244,       32'h240,       1);
    vecs[6]  = mk(0, 1, 32'h300,       0, 0, 32'h0,     0, 32'h0,        32'h300,       32'h244,       1);
    vecs[7]  = mk(0, 1, 32'h340,       0, 0, 32'h0,     0, 32'h0,        32'h340,       32'h300,       1);
    vecs[8]  = mk(0, 0, 32'h0,         1, 0, 32'h0,     1, 32'h304,      32'h304,       32'h340,       0);
    vecs[9]  = mk(0, 0, 32'h0,         1, 0, 32'h0,     0, 32'h0,        32'h308,       32'h304,       1);
    vecs[10] = mk(0, 1, 32'h400,       0, 0, 32'h0,     0, 32'h0,        32'h400,       32'h308,       1);
    vecs[11] = mk(0, 1, 32'h900,       1, 1, 32'h480,   1, 32'h480,      32'h480,       32'h400,       0);
    vecs[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,        32'h484,       32'h480,       1);
    vecs[13] = mk(0, 1, 32'h600,       0, 0, 32'h0,     0, 32'h0,        32'h600,       32'h484,       1);
    vecs[14] = mk(1, 0, 32'h0,         1, 0, 32'h0,     0, 32'h0,        32'h600,       32'h484,       1);
    vecs[15] = mk(1, 1, 32'h700,       1, 0, 32'h0,     0, 32'h0,        32'h600,       32'h484,       1);
    vecs[16] = mk(0, 0, 32'h0,         1, 0, 32'h0,     1, 32'h488,      32'h488,       32'h600,       0);
    vecs[17] = mk(1, 0, 32'h0,         1, 0, 32'h0,     0, 32'h0,        32'h488,       32'h600,       0);
    vecs[18] = mk(0, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,        32'h48C,       32'h488,       1);
    vecs[19] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,     0, 32'h0,        32'hFFFF_FFFC, 32'h48C,       1);
    vecs[20] = mk(0, 1, 32'h10,        0, 0, 32'h0,     0, 32'h0,        32'h10,        32'hFFFF_FFFC, 1);
    vecs[21] = mk(0, 0, 32'h0,         1, 0, 32'h0,     1, 32'h0,        32'h0,         32'h10,        0);

    // Reset values, checked while reset is held.
    idle_inputs();
    B_valid = 1'b1;
    #12;
    check("rst PC_IF", PC_IF, RST_PC);
    check("rst PC_ID", PC_ID, 32'h0);
    check("rst valid_ID", {31'd0, valid_ID}, 32'd0);
    check("rst pred_taken_ID", {31'd0, pred_taken_ID}, 32'd0);
    check("rst pred_target_ID", pred_target_ID, 32'h0);
    check("rst flush", {31'd0, flush}, 32'd0);
    check("rst stat_branches", stat_branches, 32'd0);
    check("rst stat_mispredicts", stat_mispredicts, 32'd0);
    release_reset();

    for (int i = 0; i < 22; i++) begin
      stall = vecs[i].st; predict = vecs[i].pr; predictedPC = vecs[i].pp;
      B_valid = vecs[i].bv; Branch_ID = vecs[i].br; jump_PC_ID = vecs[i].jpc;
      #4;
      check($sformatf("vec%0d flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
      if (vecs[i].e_flush) check($sformatf("vec%0d redirect_PC", i), redirect_PC, vecs[i].e_redir);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d PC_IF", i), PC_IF, vecs[i].e_pc_if);
      check($sformatf("vec%0d PC_ID", i), PC_ID, vecs[i].e_pc_id);
      check($sformatf("vec%0d valid_ID", i), {31'd0, valid_ID}, {31'd0, vecs[i].e_valid});
    end
`ifdef BPU_STATS_EN
    check("table stat_branches", stat_branches, 32'd5);
    check("table stat_mispredicts", stat_mispredicts, 32'd4);
`else
    check("table stat_branches", stat_branches, 32'd0);
    check("table stat_mispredicts", stat_mispredicts, 32'd0);
`endif

    // 5 resolved branches with 2 mispredicts, then async reset while in RECOVER.
    rst = 1'b0;
    #3;
    release_reset();
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 1, 32'h800);
    cyc(0, 0, 32'h0, 1, 1, 32'h800);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    cyc(0, 1, 32'hA00, 1, 1, 32'h900);
    check("recover PC_IF", PC_IF, 32'h900);
    check("recover valid_ID", {31'd0, valid_ID}, 32'd0);
`ifdef BPU_STATS_EN
    check("seq stat_branches", stat_branches, 32'd5);
    check("seq stat_mispredicts", stat_mispredicts, 32'd2);
`else
    check("seq stat_branches", stat_branches, 32'd0);
    check("seq stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    #2;
    rst = 1'b0;
    #1;
    check("async PC_IF", PC_IF, RST_PC);
    check("async PC_ID", PC_ID, 32'h0);
    check("async valid_ID", {31'd0, valid_ID}, 32'd0);
    check("async flush", {31'd0, flush}, 32'd0);
    check("async stat_branches", stat_branches, 32'd0);
    check("async stat_mispredicts", stat_mispredicts, 32'd0);
    release_reset();
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299, 0) == 0) begin
        rst = 1'b0;
        model_reset();
        #2;
        compare_all(1'b0, 1'b0, 1'b0, 32'h0);
        release_reset();
      end
      r_st  = ($urandom_range(4, 0) == 0);
      r_pr  = ($urandom_range(2, 0) == 0);
      r_pp  = $urandom() & 32'hFFFF_FFFC;
      r_bv  = ($urandom_range(4, 0) < 3);
      r_br  = $urandom_range(1, 0) == 1;
      r_jpc = ($urandom_range(1, 0) == 1) ? m_id.target : ($urandom() & 32'hFFFF_FFFC);
      cyc(r_st, r_pr, r_pp, r_bv, r_br, r_jpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_steer.md
# fetch_pc_steer

Fetch-side consumer of the branch target buffer's prediction interface and producer of its resolution interface. Owns the IF program counter. Each cycle it selects the next fetch address from the sequential PC, the predicted target, or a corrected target. It carries the prediction for each fetched instruction through IF/ID and, when the branch resolves in ID, compares the full 32-bit outcome against that prediction to raise redirect/flush.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; freezes all state, suppresses flush/redirect.
- predict  in  1  predictor says PC_IF is a taken branch.
- predictedPC  in  32  predicted target for PC_IF.
- PC_IF  out  32  current fetch address (register).
- PC_ID  out  32  address of the instruction in ID (register).
- valid_ID  out  1  ID holds a real instruction; 0 = bubble.
- pred_taken_ID  out  1  prediction carried with the ID instruction.
- pred_target_ID  out  32  predicted target carried with the ID instruction.
- B_valid  in  1  ID instruction is a conditional branch; ignored when valid_ID=0.
- Branch_ID  in  1  branch actually taken.
- jump_PC_ID  in  32  actual branch target.
- flush  out  1  combinational; kill the instruction currently in IF.
- redirect_PC  out  32  combinational corrected next PC; meaningful when flush=1.
- stat_branches  out  32  resolved-branch count (see Configuration).
- stat_mispredicts  out  32  mispredict count (see Configuration).

## Operation
- Reset values: PC_IF=RESET_PC, PC_ID=0, valid_ID=0, pred_taken_ID=0, pred_target_ID=0, state=BOOT, counters=0; flush=0 while in reset.
- resolve = valid_ID & B_valid & ~stall & (state==RUN).
- mispredict = resolve & ((Branch_ID != pred_taken_ID) | (Branch_ID & (jump_PC_ID != pred_target_ID))).
- flush = mispredict. redirect_PC = Branch_ID ? jump_PC_ID : PC_ID+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0).
- Next PC priority: stall (hold) > mispredict (redirect_PC) > predict (predictedPC) > PC_IF+4.
- IF/ID update when not stalled: PC_ID<=PC_IF, pred_taken_ID<=predict, pred_target_ID<=predictedPC, valid_ID<=~mispredict & (state!=BOOT).
- States:
  - BOOT: the first cycle after reset release. Fetches RESET_PC and goes to RUN. The ID stage is a bubble.
  - RUN: normal operation. On mispredict it goes to RECOVER.
  - RECOVER: one cycle. ID holds the killed bubble and no resolution occurs. Fetch from the corrected PC proceeds with normal prediction. It goes to RUN.
- A state transition happens only on a non-stalled edge. Stall in any state holds that state.
- A predict asserted on the same cycle as a mispredict is discarded, because the mispredict redirect wins.
- Resolution with valid_ID=0 is ignored: no flush, no count.

## Timing
- Prediction use: predict/predictedPC sampled at cycle t become PC_IF at t+1. There are no fetch bubbles for a correctly predicted taken branch.
- Mispredict resolved at cycle t: flush high during t. At t+1, PC_IF=redirect_PC, valid_ID=0 and state=RECOVER. At t+2, valid_ID=1 with state=RUN.
- The mispredict penalty is exactly 1 cycle.
- Async reset assertion mid-operation: all registers return to their reset values immediately, including during RECOVER or stall. The first fetch after release is RESET_PC.

## Configuration
- BPU_STATS_EN defined:
  - stat_branches increments on every resolve.
  - stat_mispredicts increments on every mispredict.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by reset.
- BPU_STATS_EN undefined: no counter registers; both stat outputs are constant 0. Ports remain present.

## Test plan
- Reset/boot: release rst with RESET_PC=32'h100 and predict=0. PC_IF reads 100, 104, 108 on successive edges. valid_ID=0 for the first edge, then 1. flush never asserts.
- Correct taken prediction: at PC_IF=32'h200, predict=1 and predictedPC=32'h240. Next PC_IF=240. In ID, B_valid=1, Branch_ID=1, jump_PC_ID=240. Required: flush=0 and no bubble.
- Direction mispredict: ID holds 32'h300 with pred_taken_ID=1, B_valid=1, Branch_ID=0. Required: flush=1, redirect_PC=32'h304, next PC_IF=304, valid_ID=0 for one cycle.
- Target mispredict: pred_target_ID=32'h400 but jump_PC_ID=32'h480 with Branch_ID=1. Required: flush=1, next PC_IF=480. A predict=1 in the same cycle is overridden.
- Stall: assert stall during a would-be mispredict. Required: flush=0 and PC_IF/PC_ID/state held. Deassert stall: flush=1 in that cycle.
- Stats (BPU_STATS_EN): 5 resolved branches including 2 mispredicts give stat_branches=5 and stat_mispredicts=2. Async reset mid-RECOVER clears both counters and returns PC_IF to RESET_PC.
